// File: rtl/slide_scan.sv
// Round-robin A2D scanner: walks a channel list, keeps one (optionally IIR-smoothed)
// result per slot, with settling gaps, conversion timeout and update/scan strobes.
module slide_scan #(
    parameter int                  NUM_CH      = 6,
    parameter int                  RES_W       = 12,
    parameter logic [NUM_CH*3-1:0] CH_MAP      = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
    parameter int                  AVG_SH      = 0,
    parameter int                  SETTLE_CYC  = 4,
    parameter int                  CNV_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    cnv_cmplt,
    input  logic [RES_W-1:0]        res,
    output logic [2:0]              chnnl,
    output logic                    strt_cnv,
    output logic [NUM_CH*RES_W-1:0] pot,
    output logic [NUM_CH-1:0]       pot_upd,
    output logic                    scan_done,
    output logic                    cnv_err
);

    localparam int SET_N = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam int CNT_MAX = (CNV_TIMEOUT > SET_N) ? CNV_TIMEOUT : SET_N;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(CNV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SET_N - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, UPDATE, SETTLE} state_t;

    state_t                         state;
    logic [IDX_W-1:0]               idx;
    logic [IDX_W-1:0]               idx_nxt;
    logic [CNT_W-1:0]               cnt;
    logic [RES_W-1:0]               cap;
    logic [NUM_CH-1:0][RES_W-1:0]   slot;
    logic [RES_W-1:0]               cur;
    logic signed [RES_W:0]          diff;
    logic signed [RES_W:0]          dstep;
    logic [RES_W-1:0]               iir;

    function automatic logic [2:0] ch_of(input logic [IDX_W-1:0] i);
        return CH_MAP[3*i +: 3];
    endfunction

    assign idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    // IIR step stays between old slot and new sample, so truncation back to RES_W is exact.
    assign cur   = slot[idx];
    assign diff  = $signed({1'b0, cap}) - $signed({1'b0, cur});
    assign dstep = diff >>> AVG_SH;
    assign iir   = RES_W'({1'b0, cur} + $unsigned(dstep));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            cap       <= '0;
            chnnl     <= CH_MAP[2:0];
            strt_cnv  <= 1'b0;
            scan_done <= 1'b0;
            cnv_err   <= 1'b0;
        end else begin
            strt_cnv  <= 1'b0;
            scan_done <= 1'b0;
            cnv_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state    <= START;
                        strt_cnv <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (cnv_cmplt) begin
                        cap   <= res;
                        state <= UPDATE;
                    end else if (cnt == TO_LAST) begin
                        cnv_err <= 1'b1;
                        cnt     <= '0;
                        state   <= SETTLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                UPDATE: begin
                    cnt   <= '0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == SET_LAST) begin
                        idx       <= idx_nxt;
                        chnnl     <= ch_of(idx_nxt);
                        scan_done <= (idx == IDX_LAST);
                        if (en) begin
                            state    <= START;
                            strt_cnv <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // First sample after reset loads raw so the filter does not crawl up from zero.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        logic [RES_W-1:0] val;
        logic             primed;
        logic             upd_q;
        logic             wr;

        assign wr = (state == UPDATE) && (idx == IDX_W'(k));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                val    <= '0;
                primed <= 1'b0;
                upd_q  <= 1'b0;
            end else begin
                upd_q <= wr;
                if (wr) begin
                    val    <= (primed && AVG_SH != 0) ? iir : cap;
                    primed <= 1'b1;
                end
            end
        end

        assign slot[k]    = val;
        assign pot_upd[k] = upd_q;
    end

    assign pot = slot;

endmodule

// File: tb/tb_slide_scan.sv
// Directed bench for slide_scan: raw default instance plus an IIR/short-timeout instance.
module tb_slide_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        rst0_n = 1'b0, en0 = 1'b0, cmplt0 = 1'b0;
    logic [11:0] res0 = '0;
    logic [2:0]  chnnl0;
    logic        strt0, done0, err0;
    logic [71:0] pot0;
    logic [5:0]  upd0;

    logic        rst1_n = 1'b0, en1 = 1'b0, cmplt1 = 1'b0;
    logic [11:0] res1 = '0;
    logic [2:0]  chnnl1;
    logic        strt1, done1, err1;
    logic [71:0] pot1;
    logic [5:0]  upd1;

    slide_scan u0 (
        .clk(clk), .rst_n(rst0_n), .en(en0), .cnv_cmplt(cmplt0), .res(res0),
        .chnnl(chnnl0), .strt_cnv(strt0), .pot(pot0), .pot_upd(upd0),
        .scan_done(done0), .cnv_err(err0)
    );

    slide_scan #(.AVG_SH(2), .CNV_TIMEOUT(64)) u1 (
        .clk(clk), .rst_n(rst1_n), .en(en1), .cnv_cmplt(cmplt1), .res(res1),
        .chnnl(chnnl1), .strt_cnv(strt1), .pot(pot1), .pot_upd(upd1),
        .scan_done(done1), .cnv_err(err1)
    );

    // A2D models: answer strt_cnv after dlyN cycles with tblN[channel]
    logic [11:0] tbl0[8], tbl1[8];
    int          dly0 = 20, dly1 = 20, pend0 = 0, pend1 = 0;
    logic [2:0]  lch0 = '0, lch1 = '0;
    bit          blk1[8];
    bit          stray0 = 1'b0;

    always @(negedge clk) begin
        cmplt0 = 1'b0;
        if (!rst0_n) pend0 = 0;
        else begin
            if (pend0 > 0) begin
                pend0--;
                if (pend0 == 0) begin cmplt0 = 1'b1; res0 = tbl0[lch0]; end
            end
            if (strt0) begin pend0 = dly0; lch0 = chnnl0; end
            if (stray0) begin cmplt0 = 1'b1; res0 = 12'hABC; end
        end
    end

    always @(negedge clk) begin
        cmplt1 = 1'b0;
        if (!rst1_n) pend1 = 0;
        else begin
            if (pend1 > 0) begin
                pend1--;
                if (pend1 == 0) begin cmplt1 = 1'b1; res1 = tbl1[lch1]; end
            end
            if (strt1) begin pend1 = blk1[chnnl1] ? 0 : dly1; lch1 = chnnl1; end
        end
    end

    // Event monitors
    int         n_strt0 = 0, n_done0 = 0, n_upd0 = 0, n_err1 = 0, n_upd1_2 = 0, viol = 0;
    int         last_upd0 = -1, gap_n0 = 0, gap_bad0 = 0;
    bit         gap_on0 = 1'b0;
    logic [2:0] chq0[$];

    always @(negedge clk) begin
        if (strt0) begin
            n_strt0++;
            chq0.push_back(chnnl0);
            if (gap_on0 && last_upd0 >= 0) begin
                gap_n0++;
                if (cyc - last_upd0 != 4) gap_bad0++;
            end
            last_upd0 = -1;
        end
        if (upd0 != '0) begin n_upd0++; last_upd0 = cyc; end
        if (done0) n_done0++;
        if (err1) n_err1++;
        if (upd1[2]) n_upd1_2++;
        if ($countones({strt0, |upd0, err0}) > 1 || $countones(upd0) > 1) viol++;
        if ($countones({strt1, |upd1, err1}) > 1 || $countones(upd1) > 1) viol++;
    end

    function automatic logic [11:0] sl(input logic [71:0] p, input int k);
        return p[12*k +: 12];
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_strt0(input int ch, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            step(1);
            ok = strt0 && (ch < 0 || int'(chnnl0) == ch);
        end
    endtask

    task automatic wait_strt1(input int ch, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            step(1);
            ok = strt1 && (ch < 0 || int'(chnnl1) == ch);
        end
    endtask

    task automatic wait_upd0(input int k, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin step(1); ok = upd0[k]; end
    endtask

    task automatic wait_upd1(input int k, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin step(1); ok = upd1[k]; end
    endtask

    task automatic test_reset();
        step(3);
        n_cmp++; if (chnnl0 !== 3'd0) begin n_fail++; $display("FAIL rst_chnnl0: got %0d want 0", chnnl0); end
        n_cmp++; if (pot0 !== '0) begin n_fail++; $display("FAIL rst_pot0: got %h want 0", pot0); end
        n_cmp++; if ({strt0, upd0, done0, err0} !== 9'd0) begin n_fail++; $display("FAIL rst_strobes0: got %b want 0", {strt0, upd0, done0, err0}); end
        n_cmp++; if (pot1 !== '0 || chnnl1 !== 3'd0) begin n_fail++; $display("FAIL rst_dut1: got pot=%h ch=%0d want 0/0", pot1, chnnl1); end
        rst0_n = 1'b1; rst1_n = 1'b1;
        step(4);
        n_cmp++; if (n_strt0 !== 0) begin n_fail++; $display("FAIL idle_no_strt: got %0d want 0", n_strt0); end
    endtask

    task automatic test_raw_scan();
        logic [2:0] exp_ch[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        bit ok;
        for (int k = 0; k < 6; k++) tbl0[exp_ch[k]] = 12'(100 * (k + 1));
        gap_on0 = 1'b1;
        chq0.delete();
        en0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin step(1); ok = (n_done0 == 1); end
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL raw_scan_done: got %0d want 1 within 400 cycles", n_done0); end
        n_cmp++; if (n_upd0 !== 6) begin n_fail++; $display("FAIL raw_upd_count: got %0d want 6", n_upd0); end
        n_cmp++; if (chq0.size() < 6) begin n_fail++; $display("FAIL raw_strt_count: got %0d want >=6", chq0.size()); end
        else for (int k = 0; k < 6; k++) begin
            n_cmp++; if (chq0[k] !== exp_ch[k]) begin n_fail++; $display("FAIL raw_chnnl[%0d]: got %0d want %0d", k, chq0[k], exp_ch[k]); end
        end
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (sl(pot0, k) !== 12'(100 * (k + 1))) begin n_fail++; $display("FAIL raw_slot[%0d]: got %0d want %0d", k, sl(pot0, k), 100 * (k + 1)); end
        end
        n_cmp++; if (gap_n0 !== 6 || gap_bad0 !== 0) begin n_fail++; $display("FAIL raw_settle_gap: got %0d gaps %0d wrong, want 6 gaps 0 wrong", gap_n0, gap_bad0); end
        gap_on0 = 1'b0;
    endtask

    task automatic test_enable_gating();
        bit ok;
        int s;
        tbl0[3] = 12'd444;
        wait_strt0(3, 200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL gate_strt3: got none want strt on ch3"); end
        step(3);
        en0 = 1'b0;
        wait_upd0(3, 40, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL gate_upd3: got none want pot_upd[3]"); end
        n_cmp++; if (sl(pot0, 3) !== 12'd444) begin n_fail++; $display("FAIL gate_slot3: got %0d want 444", sl(pot0, 3)); end
        s = n_strt0;
        step(10);
        n_cmp++; if (n_strt0 !== s) begin n_fail++; $display("FAIL gate_idle_strt: got %0d want %0d", n_strt0, s); end
        n_cmp++; if (chnnl0 !== 3'd4) begin n_fail++; $display("FAIL gate_idle_chnnl: got %0d want 4", chnnl0); end
        en0 = 1'b1;
        wait_strt0(-1, 2, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL gate_resume: got no strt want within 2 cycles"); end
        n_cmp++; if (chnnl0 !== 3'd4) begin n_fail++; $display("FAIL gate_resume_chnnl: got %0d want 4", chnnl0); end
    endtask

    task automatic test_stray();
        bit ok;
        logic [71:0] p;
        int u, s;
        wait_upd0(4, 40, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL stray_upd4: got none want pot_upd[4]"); end
        en0 = 1'b0;
        p = pot0; u = n_upd0; s = n_strt0;
        stray0 = 1'b1; step(1); stray0 = 1'b0;
        step(12);
        stray0 = 1'b1; step(1); stray0 = 1'b0;
        step(3);
        n_cmp++; if (pot0 !== p) begin n_fail++; $display("FAIL stray_pot: got %h want %h", pot0, p); end
        n_cmp++; if (n_upd0 !== u) begin n_fail++; $display("FAIL stray_upd: got %0d want %0d", n_upd0, u); end
        n_cmp++; if (n_strt0 !== s) begin n_fail++; $display("FAIL stray_strt: got %0d want %0d", n_strt0, s); end
        n_cmp++; if (sl(pot0, 4) !== 12'd500) begin n_fail++; $display("FAIL stray_slot4: got %0d want 500", sl(pot0, 4)); end
    endtask

    task automatic test_iir();
        bit ok;
        for (int c = 0; c < 8; c++) tbl1[c] = 12'h400;
        tbl1[0] = 12'h800;
        en1 = 1'b1;
        wait_upd1(0, 60, ok);
        n_cmp++; if (!ok || sl(pot1, 0) !== 12'h800) begin n_fail++; $display("FAIL iir_prime: got %h (seen=%0d) want 800", sl(pot1, 0), ok); end
        tbl1[0] = 12'h000;
        step(1);
        wait_upd1(0, 250, ok);
        n_cmp++; if (!ok || sl(pot1, 0) !== 12'h600) begin n_fail++; $display("FAIL iir_down: got %h (seen=%0d) want 600", sl(pot1, 0), ok); end
        tbl1[0] = 12'hFFF;
        step(1);
        wait_upd1(0, 250, ok);
        n_cmp++; if (!ok || sl(pot1, 0) !== 12'h87F) begin n_fail++; $display("FAIL iir_up: got %h (seen=%0d) want 87f", sl(pot1, 0), ok); end
        n_cmp++; if (sl(pot1, 1) !== 12'h400) begin n_fail++; $display("FAIL iir_slot1: got %h want 400", sl(pot1, 1)); end
    endtask

    task automatic test_timeout();
        bit ok, got;
        int s, u, e;
        blk1[2] = 1'b1;
        wait_strt1(2, 100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL to_strt2: got none want strt on ch2"); end
        s = cyc; u = n_upd1_2; e = n_err1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin step(1); got = err1; end
        n_cmp++; if (!got || cyc - s !== 65) begin n_fail++; $display("FAIL to_err_time: got %0d cycles (seen=%0d) want 65", cyc - s, got); end
        step(1);
        n_cmp++; if (err1 !== 1'b0 || n_err1 !== e + 1) begin n_fail++; $display("FAIL to_err_pulse: got err=%b count=%0d want 0/%0d", err1, n_err1, e + 1); end
        n_cmp++; if (sl(pot1, 2) !== 12'h400 || n_upd1_2 !== u) begin n_fail++; $display("FAIL to_slot2: got %h upd=%0d want 400 upd=%0d", sl(pot1, 2), n_upd1_2, u); end
        wait_strt1(-1, 6, ok);
        n_cmp++; if (!ok || chnnl1 !== 3'd3) begin n_fail++; $display("FAIL to_next_ch: got %0d (seen=%0d) want 3", chnnl1, ok); end
        // answer in the very last WAIT cycle: completion must beat the timeout
        blk1[2] = 1'b0;
        dly1 = 64;
        tbl1[2] = 12'h800;
        e = n_err1;
        wait_upd1(2, 700, ok);
        n_cmp++; if (!ok || sl(pot1, 2) !== 12'h500) begin n_fail++; $display("FAIL to_last_cycle: got %h (seen=%0d) want 500", sl(pot1, 2), ok); end
        n_cmp++; if (n_err1 !== e) begin n_fail++; $display("FAIL to_last_no_err: got %0d want %0d", n_err1, e); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        dly1 = 20;
        wait_strt1(-1, 100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rm_strt: got none want strt"); end
        step(5);
        #2 rst1_n = 1'b0;
        #1;
        n_cmp++; if (pot1 !== '0) begin n_fail++; $display("FAIL rm_pot: got %h want 0", pot1); end
        n_cmp++; if (chnnl1 !== 3'd0) begin n_fail++; $display("FAIL rm_chnnl: got %0d want 0", chnnl1); end
        n_cmp++; if ({strt1, upd1, done1, err1} !== 9'd0) begin n_fail++; $display("FAIL rm_strobes: got %b want 0", {strt1, upd1, done1, err1}); end
        step(2);
        tbl1[0] = 12'h123;
        rst1_n = 1'b1;
        wait_upd1(0, 60, ok);
        n_cmp++; if (!ok || sl(pot1, 0) !== 12'h123) begin n_fail++; $display("FAIL rm_raw_reload: got %h (seen=%0d) want 123", sl(pot1, 0), ok); end
    endtask

    task automatic test_exclusive();
        n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d cycles want 0", viol); end
    endtask

    initial begin
        for (int c = 0; c < 8; c++) begin tbl0[c] = '0; tbl1[c] = '0; blk1[c] = 1'b0; end
        test_reset();
        test_raw_scan();
        test_enable_gating();
        test_stray();
        test_iir();
        test_timeout();
        test_reset_mid();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
